// File: rtl/psk_code_pkg.sv
// Shared definitions for the PSK spreading-code generator / tracker family.
package psk_code_pkg;

    localparam int              CODE_LEN  = 16;
    localparam logic [15:0]     CODE_INIT = 16'h00FF;

    typedef enum logic {
        SEARCH,
        TRACK
    } trk_state_t;

    // Signed accumulator width able to hold +/-n_chips with margin.
    function automatic int acc_width(input int n_chips);
        return $clog2(n_chips) + 2;
    endfunction

endpackage

// File: rtl/psk_code_tracker_if.sv
// Chip stream in, tracking controls and correlation results out.
interface psk_code_tracker_if #(
    parameter int ACC_W = psk_code_pkg::acc_width(psk_code_pkg::CODE_LEN * 4)
);

    logic                    chip_valid;
    logic                    chip_in;
    logic                    left;
    logic                    right;
    logic                    corr_valid;
    logic signed [ACC_W-1:0] prompt_corr;
    logic                    locked;

    modport master (
        output chip_valid, chip_in,
        input  left, right, corr_valid, prompt_corr, locked
    );

    modport slave (
        input  chip_valid, chip_in,
        output left, right, corr_valid, prompt_corr, locked
    );

endinterface

// File: rtl/psk_corr_acc.sv
// Signed +/-1 correlation accumulator with synchronous dump-clear.
// 'sum' is the running total including the chip currently presented.
module psk_corr_acc #(
    parameter int ACC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    hit,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] step;

    // Current chip contributes +1 on agreement, -1 otherwise.
    always_comb begin
        step = hit ? ACC_W'(1) : '1;
        sum  = acc_q + step;
    end

    // Integrate on each chip; a dump restarts the next chip from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= clr ? '0 : sum;
        end
    end

endmodule

// File: rtl/psk_code_tracker.sv
// Early/prompt/late code-phase search and tracking for the PSK spreading code.
// Replica ref[0..CODE_LEN-1] is held in code_q with ref[0] at the MSB, so a
// one-chip step is a left rotate of code_q.
module psk_code_tracker #(
    parameter int                  CODE_LEN      = psk_code_pkg::CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE_INIT     = psk_code_pkg::CODE_INIT,
    parameter int                  INTEG_PERIODS = 4,
    parameter int                  LOCK_THRESH   = 52,
    parameter int                  LOSS_DUMPS    = 2
) (
    input  logic              clk,
    input  logic              rst,
    psk_code_tracker_if.slave bus
);

    localparam int N      = CODE_LEN * INTEG_PERIODS;
    localparam int ACC_W  = psk_code_pkg::acc_width(N);
    localparam int CNT_W  = $clog2(N);
    localparam int LOSS_W = $clog2(LOSS_DUMPS + 1);

    logic [CODE_LEN-1:0]        code_q;
    logic                       late_q;
    logic [CNT_W-1:0]           chip_cnt;
    logic                       pend_adv;
    logic                       pend_ret;
    psk_code_pkg::trk_state_t   state;
    logic [LOSS_W-1:0]          loss_cnt;

    logic                       prompt_tap;
    logic                       early_tap;
    logic                       dump;
    logic signed [ACC_W-1:0]    e_sum;
    logic signed [ACC_W-1:0]    p_sum;
    logic signed [ACC_W-1:0]    l_sum;
    logic [ACC_W-1:0]           e_mag;
    logic [ACC_W-1:0]           p_mag;
    logic [ACC_W-1:0]           l_mag;
    logic                       p_good;
    logic                       loss_last;

    // Magnitude with the most negative value clamped to the most positive.
    function automatic logic [ACC_W-1:0] mag_sat(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] neg;
        neg = -x;
        if (x >= 0) begin
            return $unsigned(x);
        end else if (neg < 0) begin
            return {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            return $unsigned(neg);
        end
    endfunction

    assign prompt_tap = code_q[CODE_LEN-1];
    assign early_tap  = code_q[CODE_LEN-2];
    assign dump       = bus.chip_valid && (chip_cnt == CNT_W'(N - 1));

    psk_corr_acc #(.ACC_W(ACC_W)) u_acc_early (
        .clk (clk),
        .rst (rst),
        .en  (bus.chip_valid),
        .clr (dump),
        .hit (bus.chip_in ~^ early_tap),
        .sum (e_sum)
    );

    psk_corr_acc #(.ACC_W(ACC_W)) u_acc_prompt (
        .clk (clk),
        .rst (rst),
        .en  (bus.chip_valid),
        .clr (dump),
        .hit (bus.chip_in ~^ prompt_tap),
        .sum (p_sum)
    );

    psk_corr_acc #(.ACC_W(ACC_W)) u_acc_late (
        .clk (clk),
        .rst (rst),
        .en  (bus.chip_valid),
        .clr (dump),
        .hit (bus.chip_in ~^ late_q),
        .sum (l_sum)
    );

    // Dump-time magnitudes and decision qualifiers (final chip included).
    always_comb begin
        e_mag     = mag_sat(e_sum);
        p_mag     = mag_sat(p_sum);
        l_mag     = mag_sat(l_sum);
        p_good    = (p_mag >= ACC_W'(LOCK_THRESH));
        loss_last = (loss_cnt == LOSS_W'(LOSS_DUMPS - 1));
    end

    // Replica stepping and chip counter; a pending advance/hold applies to the
    // chip after the dump that requested it, after that chip's taps are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= CODE_INIT;
            late_q   <= CODE_INIT[0];
            chip_cnt <= '0;
        end else if (bus.chip_valid) begin
            late_q <= prompt_tap;
            if (pend_ret) begin
                code_q <= code_q;
            end else if (pend_adv) begin
                code_q <= {code_q[CODE_LEN-3:0], code_q[CODE_LEN-1:CODE_LEN-2]};
            end else begin
                code_q <= {code_q[CODE_LEN-2:0], code_q[CODE_LEN-1]};
            end
            chip_cnt <= dump ? '0 : chip_cnt + CNT_W'(1);
        end
    end

    // Search/track FSM with registered dump results and phase pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= psk_code_pkg::SEARCH;
            loss_cnt        <= '0;
            pend_adv        <= 1'b0;
            pend_ret        <= 1'b0;
            bus.left        <= 1'b0;
            bus.right       <= 1'b0;
            bus.corr_valid  <= 1'b0;
            bus.prompt_corr <= '0;
            bus.locked      <= 1'b0;
        end else begin
            bus.left       <= 1'b0;
            bus.right      <= 1'b0;
            bus.corr_valid <= 1'b0;
            // Pending flags are consumed by the chip that follows a dump; a
            // dump on this same chip re-arms them below (later write wins).
            if (bus.chip_valid) begin
                pend_adv <= 1'b0;
                pend_ret <= 1'b0;
            end
            if (dump) begin
                bus.corr_valid  <= 1'b1;
                bus.prompt_corr <= p_sum;
                case (state)
                    psk_code_pkg::SEARCH: begin
                        if (p_good) begin
                            state      <= psk_code_pkg::TRACK;
                            bus.locked <= 1'b1;
                            loss_cnt   <= '0;
                        end else begin
                            bus.left <= 1'b1;
                            pend_adv <= 1'b1;
                        end
                    end
                    psk_code_pkg::TRACK: begin
                        if (!p_good && loss_last) begin
                            state      <= psk_code_pkg::SEARCH;
                            bus.locked <= 1'b0;
                            loss_cnt   <= '0;
                        end else begin
                            loss_cnt <= p_good ? '0 : loss_cnt + LOSS_W'(1);
                            if (e_mag > l_mag) begin
                                bus.left <= 1'b1;
                                pend_adv <= 1'b1;
                            end else if (l_mag > e_mag) begin
                                bus.right <= 1'b1;
                                pend_ret  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state      <= psk_code_pkg::SEARCH;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psk_code_tracker.sv
// Directed bench for psk_code_tracker: alignment, inversion, search sweep,
// tracking slip, loss of lock and mid-integration reset.
module tb_psk_code_tracker;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    psk_code_tracker_if #(.ACC_W(8)) bus ();

    psk_code_tracker #(
        .CODE_LEN      (16),
        .CODE_INIT     (16'h00FF),
        .INTEG_PERIODS (4),
        .LOCK_THRESH   (52),
        .LOSS_DUMPS    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          g;
    logic [15:0] code_v   = 16'h00FF;
    int          n_cv;
    int          cv_at;
    int          cv_p;
    int          cv_left;
    int          cv_right;
    int          cv_locked;
    int          stray;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Generator chip i: first chip is the MSB of the code literal.
    function automatic logic code_bit(input int i);
        return code_v[15 - (i % 16)];
    endfunction

    task automatic send_chip(input logic c);
        bus.chip_valid = 1'b1;
        bus.chip_in    = c;
        @(posedge clk);
        #1;
        bus.chip_valid = 1'b0;
    endtask

    // mode 0: code, 1: inverted code, 2: alternating 0/1 (no correlation)
    task automatic run_dump(input int mode, input int gap);
        n_cv = 0; cv_at = -1; cv_p = 9999;
        cv_left = -1; cv_right = -1; cv_locked = -1; stray = 0;
        for (int i = 0; i < N; i++) begin
            logic c;
            case (mode)
                1:       c = ~code_bit(g);
                2:       c = g[0];
                default: c = code_bit(g);
            endcase
            send_chip(c);
            g++;
            if (bus.corr_valid) begin
                n_cv++;
                cv_at     = i;
                cv_p      = int'(bus.prompt_corr);
                cv_left   = int'(bus.left);
                cv_right  = int'(bus.right);
                cv_locked = int'(bus.locked);
            end
            repeat (gap) begin
                @(posedge clk);
                #1;
                if (bus.corr_valid) stray++;
            end
        end
    endtask

    task automatic check_dump(input string tag, input int p, input int l,
                              input int r, input int lk);
        check_eq({tag, ".cv_count"}, n_cv, 1);
        check_eq({tag, ".prompt"}, cv_p, p);
        check_eq({tag, ".left"}, cv_left, l);
        check_eq({tag, ".right"}, cv_right, r);
        check_eq({tag, ".locked"}, cv_locked, lk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.chip_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_p [4] = '{16, 32, 48, 64};
        int exp_l [4] = '{1, 1, 1, 0};
        int exp_lk[4] = '{0, 0, 0, 1};

        rst = 1'b1;
        bus.chip_valid = 1'b0;
        bus.chip_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.corr_valid", int'(bus.corr_valid), 0);
        check_eq("reset.left", int'(bus.left), 0);
        check_eq("reset.right", int'(bus.right), 0);
        check_eq("reset.locked", int'(bus.locked), 0);
        check_eq("reset.prompt", int'(bus.prompt_corr), 0);
        rst = 1'b0;

        // Aligned rx with idle cycles between chips: E=L=48 tie, P=+64.
        g = 0;
        run_dump(0, 1);
        check_dump("aligned", 64, 0, 0, 1);
        check_eq("aligned.cv_at", cv_at, 63);
        check_eq("aligned.idle_pulse", stray, 0);
        check_eq("aligned.locked_hold", int'(bus.locked), 1);

        // Inverted aligned rx still locks on magnitude.
        do_reset();
        g = 0;
        run_dump(1, 0);
        check_dump("inverted", -64, 0, 0, 1);

        // rx leads replica by 3 chips: sweep 16, 32, 48, then lock at 64.
        do_reset();
        g = 3;
        for (int d = 0; d < 4; d++) begin
            run_dump(0, 0);
            check_dump($sformatf("lead3.d%0d", d + 1), exp_p[d], exp_l[d], 0, exp_lk[d]);
        end

        // rx slips one chip late: L=64, P=48, E=32 -> right; then recovers.
        g = g - 1;
        run_dump(0, 0);
        check_dump("slip", 48, 0, 1, 1);
        run_dump(0, 0);
        check_dump("slip_recover", 64, 0, 0, 1);

        // Uncorrelated rx: lock held after one bad dump, lost after two,
        // sweep resumes on the third.
        run_dump(2, 0);
        check_eq("loss1.cv_count", n_cv, 1);
        check_eq("loss1.locked", cv_locked, 1);
        run_dump(2, 0);
        check_eq("loss2.cv_count", n_cv, 1);
        check_eq("loss2.locked", cv_locked, 0);
        check_eq("loss2.left", cv_left, 0);
        check_eq("loss2.right", cv_right, 0);
        run_dump(2, 0);
        check_eq("loss3.left", cv_left, 1);
        check_eq("loss3.locked", cv_locked, 0);

        // Reset at chip 30 of a dump while locked, then a clean integration.
        do_reset();
        g = 0;
        run_dump(0, 0);
        check_eq("prereset.locked", cv_locked, 1);
        for (int i = 0; i < 30; i++) begin
            send_chip(code_bit(g));
            g++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midreset.locked", int'(bus.locked), 0);
        check_eq("midreset.prompt", int'(bus.prompt_corr), 0);
        check_eq("midreset.corr_valid", int'(bus.corr_valid), 0);
        check_eq("midreset.left", int'(bus.left), 0);
        check_eq("midreset.right", int'(bus.right), 0);
        rst = 1'b0;
        g = 0;
        run_dump(0, 0);
        check_dump("postreset", 64, 0, 0, 1);
        check_eq("postreset.cv_at", cv_at, 63);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
